pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RV64 pipeline. It drives the stall/flush pins of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, squashes wrong-path instructions on taken branches/jumps, and holds dependent stages during external data-memory stalls. It also sequences multi-cycle M-extension ops: a cycle-counting FSM holds the op in EX for its fixed latency.

Parameters:
MUL_LAT, 3, EX cycles of MUL* after the start cycle (must be >= 1)
DIV_LAT, 32, EX cycles of DIV*/REM* after the start cycle (must be >= 1)
CNT_W, $clog2(DIV_LAT+1), latency counter width (derived; do not override)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
id_rs1_addr_i  in  5  rs1 of instruction in ID
id_rs2_addr_i  in  5  rs2 of instruction in ID
ex_rd_addr_i  in  5  rd of instruction in EX
ex_mem_read_i  in  1  EX instruction is a load
ex_m_valid_i  in  1  EX instruction is an M-extension op (mul_op != M_NONE)
ex_m_is_div_i  in  1  EX M-op is DIV/DIVU/REM/REMU (W variants included)
ex_redirect_i  in  1  taken branch / JAL / JALR resolved in EX
dmem_stall_i  in  1  data memory not ready this cycle
pc_stall_o  out  1  hold PC
if_id_stall_o  out  1  hold IF/ID
if_id_flush_o  out  1  bubble IF/ID
id_ex_stall_o  out  1  hold ID/EX
id_ex_flush_o  out  1  bubble ID/EX
ex_mem_stall_o  out  1  hold EX/MEM
ex_mem_flush_o  out  1  bubble EX/MEM
mem_wb_flush_o  out  1  bubble MEM/WB
mdu_start_o  out  1  one-cycle start pulse to multiply/divide unit
mdu_busy_o  out  1  FSM in BUSY
mdu_result_valid_o  out  1  MDU result valid for EX/MEM capture this cycle

Behaviour:
- Reset is synchronous, active-low, clk only. While rst_n=0 every output is 0. At the first edge with rst_n=0, FSM goes to IDLE and cnt to 0. Reset mid-BUSY abandons the op with no start or valid afterwards.
- FSM states: IDLE, BUSY, DONE. Register cnt[CNT_W-1:0].
- IDLE:
  - ex_m_valid_i=1 and dmem_stall_i=0 and ex_redirect_i=0: mdu_start_o=1 (combinational), cnt <= (ex_m_is_div_i ? DIV_LAT : MUL_LAT)-1, next state BUSY.
  - ex_m_valid_i=1 and dmem_stall_i=1: stay IDLE, no start.
- BUSY:
  - mdu_busy_o=1.
  - cnt≠0: cnt decrements every cycle, regardless of dmem_stall_i.
  - cnt==0: next state DONE.
- DONE:
  - mdu_result_valid_o=1; the M-stall is released, so the op leaves EX.
  - dmem_stall_i=0: next state IDLE.
  - dmem_stall_i=1: hold DONE, result valid stays high.
- mstall = (IDLE & ex_m_valid_i) | BUSY.
- Op residency in EX with no memory stall = LAT+2 cycles (start, LAT busy cycles, done). mstall is high for the first LAT+1 of those cycles.
- load_use = ex_mem_read_i & (ex_rd_addr_i≠0) & (ex_rd_addr_i==id_rs1_addr_i | ex_rd_addr_i==id_rs2_addr_i).
- Output priority (combinational, first match wins; all other outputs 0):
  1. dmem_stall_i: pc, if_id, id_ex and ex_mem stall=1; mem_wb_flush=1. Redirect is deferred because EX is frozen and the redirect persists.
  2. ex_redirect_i: if_id_flush=1, id_ex_flush=1. A load-use in a killed ID is ignored.
  3. mstall: pc, if_id and id_ex stall=1; ex_mem_flush=1.
  4. load_use: pc and if_id stall=1; id_ex_flush=1 (one bubble, exactly one cycle).
- Load-use against x0 never stalls. Redirect and mstall cannot coexist because EX holds a single instruction.

Optional Feature:
PIPE_PERF_CNT_EN:
- When defined, adds outputs perf_mdu_stall_cnt_o, perf_lu_stall_cnt_o and perf_flush_cnt_o (each 32 bits).
- Each counter increments on cycles where its priority class (3, 4, 2 respectively) is the winning term. Counters wrap at 2^32 and clear on reset.
- When undefined, the ports and logic are absent.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with ex_m_valid_i=1 -> all outputs 0; after release, FSM in IDLE.
2. Load-use: ex_mem_read_i=1, ex_rd=5, id_rs2=5 -> pc/if_id stall=1 and id_ex_flush=1 for exactly 1 cycle. Repeat with ex_rd=0 -> no stall.
3. MUL with MUL_LAT=3: ex_m_valid_i=1 -> mdu_start_o pulses at cycle 0; id_ex_stall_o=1 for cycles 0-3; mdu_result_valid_o=1 at cycle 4; FSM back in IDLE at cycle 5.
4. DIV with DIV_LAT=32 plus dmem_stall_i=1 on cycles 10-12 and 33-34 -> valid first at cycle 33, held through cycle 35; FSM returns to IDLE at cycle 36.
5. Redirect coinciding with load-use: ex_redirect_i=1 -> only if_id_flush and id_ex_flush asserted, no stall. With dmem_stall_i also high -> all stalls plus mem_wb_flush, and no flush.
6. Reset asserted in BUSY at cnt=10 -> FSM in IDLE next cycle, no mdu_result_valid_o ever observed for that op.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
//
// Signals:
//   ID/EX hazard inputs : id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i,
//                         ex_mem_read_i, ex_m_valid_i, ex_m_is_div_i,
//                         ex_redirect_i, dmem_stall_i
//   Pipeline controls   : pc_stall_o, if_id_stall_o/flush_o, id_ex_stall_o/flush_o,
//                         ex_mem_stall_o/flush_o, mem_wb_flush_o
//   MDU sequencing      : mdu_start_o, mdu_busy_o, mdu_result_valid_o
//   Optional counters   : perf_mdu_stall_cnt_o, perf_lu_stall_cnt_o,
//                         perf_flush_cnt_o (present only with PIPE_PERF_CNT_EN)
//
// Modports:
//   slave  - the hazard controller (consumes hazard inputs, drives controls)
//   master - the pipeline side (drives hazard inputs, consumes controls)
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic [4:0]  ex_rd_addr_i;
    logic        ex_mem_read_i;
    logic        ex_m_valid_i;
    logic        ex_m_is_div_i;
    logic        ex_redirect_i;
    logic        dmem_stall_i;

    logic        pc_stall_o;
    logic        if_id_stall_o;
    logic        if_id_flush_o;
    logic        id_ex_stall_o;
    logic        id_ex_flush_o;
    logic        ex_mem_stall_o;
    logic        ex_mem_flush_o;
    logic        mem_wb_flush_o;
    logic        mdu_start_o;
    logic        mdu_busy_o;
    logic        mdu_result_valid_o;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_mdu_stall_cnt_o;
    logic [31:0] perf_lu_stall_cnt_o;
    logic [31:0] perf_flush_cnt_o;

    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, ex_mem_read_i,
               ex_m_valid_i, ex_m_is_div_i, ex_redirect_i, dmem_stall_i,
        output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
               id_ex_flush_o, ex_mem_stall_o, ex_mem_flush_o, mem_wb_flush_o,
               mdu_start_o, mdu_busy_o, mdu_result_valid_o,
               perf_mdu_stall_cnt_o, perf_lu_stall_cnt_o, perf_flush_cnt_o
    );

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, ex_mem_read_i,
               ex_m_valid_i, ex_m_is_div_i, ex_redirect_i, dmem_stall_i,
        input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
               id_ex_flush_o, ex_mem_stall_o, ex_mem_flush_o, mem_wb_flush_o,
               mdu_start_o, mdu_busy_o, mdu_result_valid_o,
               perf_mdu_stall_cnt_o, perf_lu_stall_cnt_o, perf_flush_cnt_o
    );
`else
    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, ex_mem_read_i,
               ex_m_valid_i, ex_m_is_div_i, ex_redirect_i, dmem_stall_i,
        output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
               id_ex_flush_o, ex_mem_stall_o, ex_mem_flush_o, mem_wb_flush_o,
               mdu_start_o, mdu_busy_o, mdu_result_valid_o
    );

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, ex_mem_read_i,
               ex_m_valid_i, ex_m_is_div_i, ex_redirect_i, dmem_stall_i,
        input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
               id_ex_flush_o, ex_mem_stall_o, ex_mem_flush_o, mem_wb_flush_o,
               mdu_start_o, mdu_busy_o, mdu_result_valid_o
    );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage RV64 pipeline. Detects
// load-use hazards, squashes wrong-path instructions on EX redirects, freezes
// the pipe during data-memory stalls and holds multi-cycle M-extension ops in
// EX with a latency-counting FSM (IDLE -> BUSY -> DONE).
//
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset (all outputs forced to 0 while low)
//   hz    - pipeline_hazard_ctrl_if.slave bundle (hazard inputs, stage
//           stall/flush controls, MDU start/busy/result-valid)
//
// Parameters:
//   MUL_LAT - EX cycles of MUL* after the start cycle (>= 1)
//   DIV_LAT - EX cycles of DIV*/REM* after the start cycle (>= 1)
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   Adds three free-running 32-bit counters of cycles lost to M-op stalls,
//   load-use stalls and redirect flushes.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam int CNT_W = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

    mdu_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             mdu_start;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mdu_start  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // A frozen EX (memory stall) must not launch the op: the start
                // pulse would be lost while the instruction is held.
                if (hz.ex_m_valid_i && !hz.dmem_stall_i && !hz.ex_redirect_i) begin
                    mdu_start  = 1'b1;
                    cnt_next   = hz.ex_m_is_div_i ? DIV_CNT_INIT : MUL_CNT_INIT;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                // The MDU runs independently of memory stalls, so keep counting.
                if (cnt_reg == '0) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_DONE: begin
                // Result stays valid until EX/MEM can actually capture it.
                if (!hz.dmem_stall_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ----------------------------------------------------- hazard priority
    logic mstall;
    logic load_use;
    logic win_dmem;
    logic win_flush;
    logic win_mstall;
    logic win_lu;

    assign mstall   = ((state_reg == S_IDLE) && hz.ex_m_valid_i) || (state_reg == S_BUSY);
    assign load_use = hz.ex_mem_read_i && (hz.ex_rd_addr_i != 5'd0) &&
                      ((hz.ex_rd_addr_i == hz.id_rs1_addr_i) ||
                       (hz.ex_rd_addr_i == hz.id_rs2_addr_i));

    // Exactly one class wins each cycle. A memory stall defers a redirect
    // (EX is frozen so the redirect is still present next cycle); a redirect
    // kills ID, so any load-use seen there is irrelevant.
    assign win_dmem   = hz.dmem_stall_i;
    assign win_flush  = !hz.dmem_stall_i && hz.ex_redirect_i;
    assign win_mstall = !hz.dmem_stall_i && !hz.ex_redirect_i && mstall;
    assign win_lu     = !hz.dmem_stall_i && !hz.ex_redirect_i && !mstall && load_use;

    assign hz.pc_stall_o         = rst_n && (win_dmem || win_mstall || win_lu);
    assign hz.if_id_stall_o      = rst_n && (win_dmem || win_mstall || win_lu);
    assign hz.if_id_flush_o      = rst_n && win_flush;
    assign hz.id_ex_stall_o      = rst_n && (win_dmem || win_mstall);
    assign hz.id_ex_flush_o      = rst_n && (win_flush || win_lu);
    assign hz.ex_mem_stall_o     = rst_n && win_dmem;
    assign hz.ex_mem_flush_o     = rst_n && win_mstall;
    assign hz.mem_wb_flush_o     = rst_n && win_dmem;
    assign hz.mdu_start_o        = rst_n && mdu_start;
    assign hz.mdu_busy_o         = rst_n && (state_reg == S_BUSY);
    assign hz.mdu_result_valid_o = rst_n && (state_reg == S_DONE);

`ifdef PIPE_PERF_CNT_EN
    // ------------------------------------------------- performance counters
    // Index 0: M-op stall cycles, 1: load-use stall cycles, 2: flush cycles.
    logic [2:0]  perf_inc;
    logic [31:0] perf_cnt_reg [3];

    assign perf_inc = {win_flush, win_lu, win_mstall};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    perf_cnt_reg[gi] <= '0;
                end else if (perf_inc[gi]) begin
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign hz.perf_mdu_stall_cnt_o = perf_cnt_reg[0];
    assign hz.perf_lu_stall_cnt_o  = perf_cnt_reg[1];
    assign hz.perf_flush_cnt_o     = perf_cnt_reg[2];
`endif
endmodule
